mem_dma: RTL and testbench
==========================

MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 Parameter WIDTH, default 8, is the data byte width; only 8 is supported.
REQ-002 Parameter ADDR_BITS, default 8, is the memory address width; only 8 (256 words) is supported.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 mode  input  1  0 = copy (read src, write dst), 1 = fill (write fill_data to dst).
REQ-007 src_adr  input  8  first source address (copy mode).
REQ-008 dst_adr  input  8  first destination address.
REQ-009 len  input  8  byte count, 0..255.
REQ-010 fill_data  input  8  pattern byte (fill mode).
REQ-011 memdata  input  8  read data from the 256x8 memory; the memory updates it on the falling clock edge.
REQ-012 adr  output  8  memory address, registered.
REQ-013 writedata  output  8  memory write data, registered.
REQ-014 memwrite  output  1  memory write enable, registered; the memory commits on the falling edge inside the cycle.
REQ-015 busy  output  1  high while a transfer is in progress.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 checksum  output  8  sum mod 256 of all bytes written by the current or last transfer.

Function
REQ-018 States: IDLE, RD, WR, DONE; all outputs are driven from registers, with no combinational path from memdata to any output.
REQ-019 IDLE with start=1 accepts the transfer: it latches src_adr, dst_adr, len, mode and fill_data, zeroes the byte index i, and clears checksum.
REQ-020 On acceptance with len=0, the next state is DONE; no memwrite is issued.
REQ-021 On acceptance with len!=0, the next state is RD (copy) or WR (fill).
REQ-022 RD cycle: adr=src+i, memwrite=0; the memory presents the data at the mid-cycle falling edge.
REQ-023 At the rising edge ending RD: writedata<=memdata, adr<=dst+i, memwrite<=1, next state WR.
REQ-024 WR cycle: adr=dst+i, memwrite=1; in fill mode, writedata=fill_data.
REQ-025 At the rising edge ending WR: checksum<=checksum+writedata, i<=i+1.
REQ-026 After that edge, if i+1==len: memwrite<=0, next state DONE.
REQ-027 Otherwise, copy mode goes to RD; fill mode stays in WR with adr<=dst+i+1.
REQ-028 Throughput: copy takes 2 cycles/byte; fill takes 1 cycle/byte.
REQ-029 done is high in the cycle 2*len+1 (copy) or len+1 (fill) after the accepting edge; for len=0 it is high in the cycle 1 after.
REQ-030 DONE lasts exactly one cycle, then the block returns to IDLE.
REQ-031 busy is high in every RD/WR cycle and low in IDLE and DONE.
REQ-032 start is ignored in RD, WR and DONE; it is not queued.
REQ-033 Address arithmetic is modulo 256: src+i and dst+i wrap from 0xFF to 0x00.
REQ-034 Copy is strictly ascending and byte-sequential, so an overlapping forward copy (dst=src+k) re-reads already-written bytes; this is the required behaviour.
REQ-035 In IDLE and DONE: memwrite=0; adr, writedata and checksum hold their last values.

Reset
REQ-036 reset_n=0 at a rising edge forces IDLE, adr=0, writedata=0, memwrite=0, busy=0, done=0, checksum=0, i=0.
REQ-037 Reset has priority over start and over any in-progress transfer; an aborted transfer issues no further writes and produces no done pulse.

Verification
REQ-038 Copy: mem[0x10..0x13]=01,02,03,04; start with mode=0, src=0x10, dst=0x80, len=4 -> mem[0x80..0x83]=01..04; memwrite high in exactly 4 cycles; done in cycle 9; checksum=0x0A.
REQ-039 Fill with wrap: mode=1, dst=0xFE, len=4, fill_data=0xA5 -> writes to 0xFE, 0xFF, 0x00, 0x01 all 0xA5; done in cycle 5; checksum=0x94.
REQ-040 Zero length: len=0 -> done in cycle 1; no memwrite; busy never high; checksum=0.
REQ-041 Overlap and ignored start: mem[0x20]=0x55, copy src=0x20, dst=0x21, len=3, start re-pulsed mid-transfer -> mem[0x21..0x23]=0x55; exactly one done pulse.
REQ-042 Reset mid-operation: reset_n=0 during the third WR cycle of a len=8 copy -> next edge memwrite=0, busy=0, checksum=0; destination bytes 3..7 unchanged; no done pulse.

Source files
------------

// File: rtl/mem_dma.sv
// Memory-to-memory DMA engine: byte copy or pattern fill over a 256x8 RAM.
// RAM reads and writes complete on the falling edge; every output is registered.
module mem_dma #(
   parameter int WIDTH     = 8,
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 mode,
   input  logic [ADDR_BITS-1:0] src_adr,
   input  logic [ADDR_BITS-1:0] dst_adr,
   input  logic [7:0]           len,
   input  logic [WIDTH-1:0]     fill_data,
   input  logic [WIDTH-1:0]     memdata,
   output logic [ADDR_BITS-1:0] adr,
   output logic [WIDTH-1:0]     writedata,
   output logic                 memwrite,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     checksum
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] src_q, src_d;
   logic [ADDR_BITS-1:0] dst_q, dst_d;
   logic [7:0]           len_q, len_d;
   logic                 mode_q, mode_d;
   logic [WIDTH-1:0]     fill_q, fill_d;
   logic [7:0]           i_q, i_d;
   logic [ADDR_BITS-1:0] adr_q, adr_d;
   logic [WIDTH-1:0]     wd_q, wd_d;
   logic                 we_q, we_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     cks_q, cks_d;
   logic [7:0]           i_nxt;

   assign i_nxt = i_q + 8'd1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         mode_q  <= 1'b0;
         fill_q  <= '0;
         i_q     <= '0;
         adr_q   <= '0;
         wd_q    <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cks_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         mode_q  <= mode_d;
         fill_q  <= fill_d;
         i_q     <= i_d;
         adr_q   <= adr_d;
         wd_q    <= wd_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cks_q   <= cks_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      mode_d  = mode_q;
      fill_d  = fill_q;
      i_d     = i_q;
      adr_d   = adr_q;
      wd_d    = wd_q;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cks_d   = cks_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               src_d  = src_adr;
               dst_d  = dst_adr;
               len_d  = len;
               mode_d = mode;
               fill_d = fill_data;
               i_d    = '0;
               cks_d  = '0;
               if (len == 8'd0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (mode) begin
                  state_d = WR;
                  adr_d   = dst_adr;
                  wd_d    = fill_data;
                  we_d    = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  state_d = RD;
                  adr_d   = src_adr;
                  busy_d  = 1'b1;
               end
            end
         end
         RD: begin
            // memdata was updated at the mid-cycle falling edge
            wd_d    = memdata;
            adr_d   = dst_q + i_q;
            we_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = WR;
         end
         WR: begin
            cks_d = cks_q + wd_q;
            i_d   = i_nxt;
            if (i_nxt == len_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (mode_q) begin
               adr_d  = dst_q + i_nxt;
               wd_d   = fill_q;
               we_d   = 1'b1;
               busy_d = 1'b1;
            end else begin
               adr_d   = src_q + i_nxt;
               busy_d  = 1'b1;
               state_d = RD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign adr       = adr_q;
   assign writedata = wd_q;
   assign memwrite  = we_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign checksum  = cks_q;

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a falling-edge 256x8 RAM model.
// Each scenario task drives one transfer and checks results inline.
module tb_mem_dma;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       mode;
   logic [7:0] src_adr;
   logic [7:0] dst_adr;
   logic [7:0] len;
   logic [7:0] fill_data;
   logic [7:0] memdata;
   logic [7:0] adr;
   logic [7:0] writedata;
   logic       memwrite;
   logic       busy;
   logic       done;
   logic [7:0] checksum;

   logic [7:0] mem [256];

   int n_chk  = 0;
   int n_fail = 0;
   int wr_cnt;
   int bz_cnt;
   int dn_cnt;
   int dn_cyc;

   mem_dma #(.WIDTH(8), .ADDR_BITS(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .mode      (mode),
      .src_adr   (src_adr),
      .dst_adr   (dst_adr),
      .len       (len),
      .fill_data (fill_data),
      .memdata   (memdata),
      .adr       (adr),
      .writedata (writedata),
      .memwrite  (memwrite),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (memwrite === 1'b1) mem[adr] = writedata;
      memdata = mem[adr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_xfer(input logic m, input logic [7:0] s,
                           input logic [7:0] d, input logic [7:0] l,
                           input logic [7:0] f, input bit repulse);
      mode      = m;
      src_adr   = s;
      dst_adr   = d;
      len       = l;
      fill_data = f;
      start     = 1'b1;
      wr_cnt    = 0;
      bz_cnt    = 0;
      dn_cnt    = 0;
      dn_cyc    = -1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (memwrite) wr_cnt++;
         if (busy) bz_cnt++;
         if (done) begin
            dn_cnt++;
            if (dn_cnt == 1) dn_cyc = k;
         end
         start = (repulse && (k == 2 || k == 3));
         src_adr = 8'h00;
         dst_adr = 8'h00;
         tick();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_chk++;
      if (adr !== 8'h00) begin
         n_fail++; $display("FAIL rst_adr got %h want 00", adr);
      end
      n_chk++;
      if (writedata !== 8'h00) begin
         n_fail++; $display("FAIL rst_wd got %h want 00", writedata);
      end
      n_chk++;
      if (memwrite !== 1'b0) begin
         n_fail++; $display("FAIL rst_we got %b want 0", memwrite);
      end
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy got %b want 0", busy);
      end
      n_chk++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL rst_done got %b want 0", done);
      end
      n_chk++;
      if (checksum !== 8'h00) begin
         n_fail++; $display("FAIL rst_cks got %h want 00", checksum);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_copy();
      logic [7:0] exp;
      for (int j = 0; j < 4; j++) mem[8'h10 + j] = 8'(j + 1);
      run_xfer(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 1'b0);
      for (int j = 0; j < 4; j++) begin
         exp = 8'(j + 1);
         n_chk++;
         if (mem[8'h80 + j] !== exp) begin
            n_fail++;
            $display("FAIL copy_mem[%0d] got %h want %h", j, mem[8'h80 + j], exp);
         end
      end
      n_chk++;
      if (wr_cnt != 4) begin
         n_fail++; $display("FAIL copy_wr_cnt got %0d want 4", wr_cnt);
      end
      n_chk++;
      if (dn_cyc != 9) begin
         n_fail++; $display("FAIL copy_done_cyc got %0d want 9", dn_cyc);
      end
      n_chk++;
      if (dn_cnt != 1) begin
         n_fail++; $display("FAIL copy_done_cnt got %0d want 1", dn_cnt);
      end
      n_chk++;
      if (bz_cnt != 8) begin
         n_fail++; $display("FAIL copy_busy_cnt got %0d want 8", bz_cnt);
      end
      n_chk++;
      if (checksum !== 8'h0A) begin
         n_fail++; $display("FAIL copy_cks got %h want 0a", checksum);
      end
   endtask

   task automatic test_fill_wrap();
      logic [7:0] a;
      mem[8'hFD] = 8'h11;
      mem[8'h02] = 8'h22;
      run_xfer(1'b1, 8'h00, 8'hFE, 8'd4, 8'hA5, 1'b0);
      for (int j = 0; j < 4; j++) begin
         a = 8'hFE + 8'(j);
         n_chk++;
         if (mem[a] !== 8'hA5) begin
            n_fail++; $display("FAIL fill_mem[%h] got %h want a5", a, mem[a]);
         end
      end
      n_chk++;
      if (mem[8'hFD] !== 8'h11 || mem[8'h02] !== 8'h22) begin
         n_fail++;
         $display("FAIL fill_edges got %h %h want 11 22", mem[8'hFD], mem[8'h02]);
      end
      n_chk++;
      if (dn_cyc != 5) begin
         n_fail++; $display("FAIL fill_done_cyc got %0d want 5", dn_cyc);
      end
      n_chk++;
      if (wr_cnt != 4) begin
         n_fail++; $display("FAIL fill_wr_cnt got %0d want 4", wr_cnt);
      end
      n_chk++;
      if (checksum !== 8'h94) begin
         n_fail++; $display("FAIL fill_cks got %h want 94", checksum);
      end
   endtask

   task automatic test_zero_len();
      run_xfer(1'b0, 8'h10, 8'h80, 8'd0, 8'h00, 1'b0);
      n_chk++;
      if (dn_cyc != 1) begin
         n_fail++; $display("FAIL zero_done_cyc got %0d want 1", dn_cyc);
      end
      n_chk++;
      if (wr_cnt != 0) begin
         n_fail++; $display("FAIL zero_wr_cnt got %0d want 0", wr_cnt);
      end
      n_chk++;
      if (bz_cnt != 0) begin
         n_fail++; $display("FAIL zero_busy_cnt got %0d want 0", bz_cnt);
      end
      n_chk++;
      if (checksum !== 8'h00) begin
         n_fail++; $display("FAIL zero_cks got %h want 00", checksum);
      end
   endtask

   task automatic test_overlap();
      mem[8'h20] = 8'h55;
      mem[8'h21] = 8'h01;
      mem[8'h22] = 8'h02;
      mem[8'h23] = 8'h03;
      mem[8'h24] = 8'h04;
      run_xfer(1'b0, 8'h20, 8'h21, 8'd3, 8'h00, 1'b1);
      for (int j = 1; j <= 3; j++) begin
         n_chk++;
         if (mem[8'h20 + j] !== 8'h55) begin
            n_fail++;
            $display("FAIL ovl_mem[%0d] got %h want 55", j, mem[8'h20 + j]);
         end
      end
      n_chk++;
      if (mem[8'h24] !== 8'h04) begin
         n_fail++; $display("FAIL ovl_tail got %h want 04", mem[8'h24]);
      end
      n_chk++;
      if (dn_cnt != 1) begin
         n_fail++; $display("FAIL ovl_done_cnt got %0d want 1", dn_cnt);
      end
      n_chk++;
      if (dn_cyc != 7) begin
         n_fail++; $display("FAIL ovl_done_cyc got %0d want 7", dn_cyc);
      end
      n_chk++;
      if (checksum !== 8'hFF) begin
         n_fail++; $display("FAIL ovl_cks got %h want ff", checksum);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp;
      for (int j = 0; j < 8; j++) begin
         mem[8'h40 + j] = 8'(j + 1);
         mem[8'h90 + j] = 8'hEE;
      end
      mode      = 1'b0;
      src_adr   = 8'h40;
      dst_adr   = 8'h90;
      len       = 8'd8;
      start     = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      n_chk++;
      if (memwrite !== 1'b1 || adr !== 8'h92) begin
         n_fail++;
         $display("FAIL mid_wr3 got we=%b adr=%h want 1 92", memwrite, adr);
      end
      reset_n = 1'b0;
      tick();
      n_chk++;
      if (memwrite !== 1'b0) begin
         n_fail++; $display("FAIL mid_we got %b want 0", memwrite);
      end
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_busy got %b want 0", busy);
      end
      n_chk++;
      if (checksum !== 8'h00) begin
         n_fail++; $display("FAIL mid_cks got %h want 00", checksum);
      end
      reset_n = 1'b1;
      dn_cnt = 0;
      wr_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) dn_cnt++;
         if (memwrite) wr_cnt++;
         tick();
      end
      n_chk++;
      if (dn_cnt != 0 || wr_cnt != 0) begin
         n_fail++;
         $display("FAIL mid_after got done=%0d wr=%0d want 0 0", dn_cnt, wr_cnt);
      end
      for (int j = 0; j < 8; j++) begin
         exp = (j < 3) ? 8'(j + 1) : 8'hEE;
         n_chk++;
         if (mem[8'h90 + j] !== exp) begin
            n_fail++;
            $display("FAIL mid_mem[%0d] got %h want %h", j, mem[8'h90 + j], exp);
         end
      end
   endtask

   initial begin
      for (int j = 0; j < 256; j++) mem[j] = 8'h00;
      memdata   = 8'h00;
      reset_n   = 1'b0;
      start     = 1'b0;
      mode      = 1'b0;
      src_adr   = 8'h00;
      dst_adr   = 8'h00;
      len       = 8'h00;
      fill_data = 8'h00;
      test_reset();
      test_copy();
      test_fill_wrap();
      test_zero_len();
      test_overlap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
